timer_bank: RTL and testbench

- Parametrised successor to the single advanced-trigger timer. Provides NUM_TIMERS independent counters of WIDTH bits each.
- Each channel has a one-shot or auto-reload mode. A shared prescaler sets the tick rate.
- Sits beside the trigger FSM. Channels are loaded through the 32-bit config write path and started, stopped or cleared by FSM strobes qualified with update_timers.
- Elapsed flags feed back into FSM state transitions.

---
 rtl/timer_pkg.sv | 32 +++
 rtl/timer_channel.sv | 103 ++++++++++
 rtl/timer_bank.sv | 89 ++++++++
 tb/tb_timer_bank.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer bank.
//   AUTO_RELOAD_BIT : bit of a channel control word that selects auto-reload.
//   limit_words()   : number of 32-bit config words needed for one limit.
//   chan_base()     : first config word address of a channel.
//   timer_cmd_t     : per-channel FSM command after update_timers qualification.
package timer_pkg;

  localparam int unsigned CFG_W           = 32;
  localparam int unsigned AUTO_RELOAD_BIT = 0;

  // Supported parameter ranges of timer_bank.
  localparam int unsigned MIN_TIMERS = 1;
  localparam int unsigned MAX_TIMERS = 8;
  localparam int unsigned MIN_WIDTH  = 8;
  localparam int unsigned MAX_WIDTH  = 64;

  typedef struct packed {
    logic start;
    logic clear;
    logic stop;
  } timer_cmd_t;

  function automatic int unsigned limit_words(input int unsigned width);
    return (width + CFG_W - 1) / CFG_W;
  endfunction

  // Each channel occupies its limit words followed by one control word.
  function automatic int unsigned chan_base(input int unsigned chan, input int unsigned width);
    return chan * (limit_words(width) + 1);
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: counter, limit, mode, active and elapsed state.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   tick_i        : shared prescaler tick; the counter only moves on a tick
//   lim_we_i      : per-word limit write enables, word w holds bits [32w+31:32w]
//   ctrl_we_i     : control word write enable (auto-reload bit)
//   wr_data_i     : config write data
//   cmd_i         : start/clear/stop, already qualified by update_timers
//   elapsed_o     : registered elapsed flag (pulse in auto-reload, level in one-shot)
//   active_o      : registered running flag
module timer_channel
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned LW    = limit_words(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick_i,
  input  logic [LW-1:0]    lim_we_i,
  input  logic             ctrl_we_i,
  input  logic [CFG_W-1:0] wr_data_i,
  input  timer_cmd_t       cmd_i,
  output logic             elapsed_o,
  output logic             active_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             auto_q, auto_d;
  logic             active_q, active_d;
  logic             elapsed_q, elapsed_d;
  logic             oneshot_done;

  // Config path; limit bits above WIDTH in the top word are simply dropped.
  always_comb begin
    limit_d = limit_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (lim_we_i[i / CFG_W]) begin
        limit_d[i] = wr_data_i[i % CFG_W];
      end
    end
    auto_d = ctrl_we_i ? wr_data_i[AUTO_RELOAD_BIT] : auto_q;
  end

  assign oneshot_done = !auto_q && elapsed_q;

  always_comb begin
    cnt_d     = cnt_q;
    active_d  = active_q;
    // Auto-reload elapsed is a single-cycle pulse; one-shot elapsed holds.
    elapsed_d = auto_q ? 1'b0 : elapsed_q;

    // Counter parks at 0 while a one-shot result is pending.
    if (oneshot_done) begin
      cnt_d = '0;
    end

    if (active_q && tick_i) begin
      // A restarted but uncleared one-shot expires on its first tick.
      if ((cnt_q >= limit_q) || oneshot_done) begin
        cnt_d     = '0;
        elapsed_d = 1'b1;
        if (!auto_q) begin
          active_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end

    // Strobe priority: start, then clear, then stop (later wins).
    if (cmd_i.start) begin
      active_d = 1'b1;
    end
    if (cmd_i.clear) begin
      cnt_d     = '0;
      elapsed_d = 1'b0;
    end
    if (cmd_i.stop) begin
      active_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      limit_q   <= '0;
      auto_q    <= 1'b0;
      active_q  <= 1'b0;
      elapsed_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      limit_q   <= limit_d;
      auto_q    <= auto_d;
      active_q  <= active_d;
      elapsed_q <= elapsed_d;
    end
  end

  assign elapsed_o = elapsed_q;
  assign active_o  = active_q;

endmodule

// File: rtl/timer_bank.sv
// Bank of NUM_TIMERS independent WIDTH-bit timers sharing one prescaler.
//   clk, reset_n      : clock, asynchronous active-low reset
//   wrenb, wraddr     : config write strobe and word address
//   config_data       : config write data (limit words, control word)
//   update_timers     : qualifies every fsm_* strobe
//   fsm_start_timer   : per-channel start
//   fsm_clear_timer   : per-channel clear (cnt and elapsed to 0)
//   fsm_stop_timer    : per-channel stop
//   timer_elapsed     : per-channel registered elapsed flag
//   timer_active      : per-channel registered running flag
// Channel c owns config words c*(LW+1) .. c*(LW+1)+LW; the last one is control.
module timer_bank
  import timer_pkg::*;
#(
  parameter int unsigned NUM_TIMERS = 2,
  parameter int unsigned WIDTH      = 36,
  parameter int unsigned PRESCALE   = 1,
  parameter int unsigned ADDR_W     = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wrenb,
  input  logic [ADDR_W-1:0]     wraddr,
  input  logic [31:0]           config_data,
  input  logic                  update_timers,
  input  logic [NUM_TIMERS-1:0] fsm_start_timer,
  input  logic [NUM_TIMERS-1:0] fsm_clear_timer,
  input  logic [NUM_TIMERS-1:0] fsm_stop_timer,
  output logic [NUM_TIMERS-1:0] timer_elapsed,
  output logic [NUM_TIMERS-1:0] timer_active
);

  localparam int unsigned LW    = limit_words(WIDTH);
  localparam int unsigned PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  // Free-running prescaler; start strobes never realign it.
  logic [PSC_W-1:0] psc_q, psc_d;
  logic             tick;

  assign tick = (psc_q == '0);

  always_comb begin
    psc_d = (psc_q == PSC_W'(PRESCALE - 1)) ? '0 : psc_q + PSC_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      psc_q <= '0;
    end else begin
      psc_q <= psc_d;
    end
  end

  for (genvar c = 0; c < NUM_TIMERS; c++) begin : g_chan
    logic [LW-1:0] lim_we;
    logic          ctrl_we;
    timer_cmd_t    cmd;

    // Addresses outside every channel window match nothing and are dropped.
    always_comb begin
      for (int unsigned w = 0; w < LW; w++) begin
        lim_we[w] = wrenb && (32'(wraddr) == chan_base(c, WIDTH) + w);
      end
      ctrl_we = wrenb && (32'(wraddr) == chan_base(c, WIDTH) + LW);
    end

    always_comb begin
      cmd.start = update_timers & fsm_start_timer[c];
      cmd.clear = update_timers & fsm_clear_timer[c];
      cmd.stop  = update_timers & fsm_stop_timer[c];
    end

    timer_channel #(
      .WIDTH (WIDTH),
      .LW    (LW)
    ) u_chan (
      .clk_i     (clk),
      .rst_ni    (reset_n),
      .tick_i    (tick),
      .lim_we_i  (lim_we),
      .ctrl_we_i (ctrl_we),
      .wr_data_i (config_data),
      .cmd_i     (cmd),
      .elapsed_o (timer_elapsed[c]),
      .active_o  (timer_active[c])
    );
  end

endmodule

// File: tb/tb_timer_bank.sv
module tb_timer_bank;

  localparam int unsigned NT = 2;
  localparam int unsigned W  = 36;
  localparam int unsigned LW = 2;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          wrenb = 1'b0;
  logic [AW-1:0] wraddr = '0;
  logic [31:0]   config_data = '0;
  logic          update_timers = 1'b0;
  logic [NT-1:0] st = '0, cl = '0, sp = '0;
  logic [NT-1:0] el1, act1, el4, act4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  timer_bank #(.NUM_TIMERS(NT), .WIDTH(W), .PRESCALE(1), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .wrenb(wrenb), .wraddr(wraddr), .config_data(config_data),
    .update_timers(update_timers), .fsm_start_timer(st), .fsm_clear_timer(cl),
    .fsm_stop_timer(sp), .timer_elapsed(el1), .timer_active(act1)
  );

  timer_bank #(.NUM_TIMERS(NT), .WIDTH(W), .PRESCALE(4), .ADDR_W(AW)) dut4 (
    .clk(clk), .reset_n(reset_n), .wrenb(wrenb), .wraddr(wraddr), .config_data(config_data),
    .update_timers(update_timers), .fsm_start_timer(st), .fsm_clear_timer(cl),
    .fsm_stop_timer(sp), .timer_elapsed(el4), .timer_active(act4)
  );

  // Reference model: index 0 = PRESCALE 1 instance, index 1 = PRESCALE 4 instance.
  longint unsigned m_cnt[2][NT];
  longint unsigned m_lim[2][NT];
  bit              m_auto[2][NT];
  bit              m_act[2][NT];
  bit              m_el[2][NT];
  int              m_phase[2];

  function automatic int ps(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0;
      for (int c = 0; c < NT; c++) begin
        m_cnt[k][c] = 0; m_lim[k][c] = 0; m_auto[k][c] = 0;
        m_act[k][c] = 0; m_el[k][c] = 0;
      end
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    longint unsigned wmask;
    int a, c, w;
    bit tick, reload, pending, expired;
    wmask = (64'd1 << W) - 1;
    for (int k = 0; k < 2; k++) begin
      tick = (m_phase[k] == 0);
      m_phase[k] = (m_phase[k] + 1) % ps(k);
      for (int ch = 0; ch < NT; ch++) begin
        reload  = m_auto[k][ch];
        pending = m_el[k][ch] && !reload;
        expired = 0;
        if (m_act[k][ch] && tick) begin
          if (pending || m_cnt[k][ch] >= m_lim[k][ch]) expired = 1;
          else m_cnt[k][ch] = m_cnt[k][ch] + 1;
        end
        if (expired) begin
          m_cnt[k][ch] = 0;
          m_el[k][ch]  = 1;
          m_act[k][ch] = reload;
        end else if (reload) begin
          m_el[k][ch] = 0;
        end
        if (pending) m_cnt[k][ch] = 0;
        if (update_timers) begin
          if (st[ch]) m_act[k][ch] = 1;
          if (cl[ch]) begin m_cnt[k][ch] = 0; m_el[k][ch] = 0; end
          if (sp[ch]) m_act[k][ch] = 0;
        end
      end
      if (wrenb) begin
        a = int'(wraddr);
        c = a / (LW + 1);
        w = a % (LW + 1);
        if (c < NT) begin
          if (w < LW) begin
            m_lim[k][c] = ((m_lim[k][c] & ~(64'hFFFF_FFFF << (32 * w)))
                           | (64'(config_data) << (32 * w))) & wmask;
          end else begin
            m_auto[k][c] = config_data[0];
          end
        end
      end
    end
  endtask

  function automatic logic [NT-1:0] mvec(input int k, input bit want_el);
    logic [NT-1:0] v;
    for (int c = 0; c < NT; c++) v[c] = want_el ? m_el[k][c] : m_act[k][c];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("act_p1", 64'(act1), 64'(mvec(0, 0)));
    chk("el_p1",  64'(el1),  64'(mvec(0, 1)));
    chk("act_p4", 64'(act4), 64'(mvec(1, 0)));
    chk("el_p4",  64'(el4),  64'(mvec(1, 1)));
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    wrenb = 1'b1; wraddr = AW'(a); config_data = d;
    cycle();
    wrenb = 1'b0;
  endtask

  task automatic strobe(input logic [NT-1:0] s, input logic [NT-1:0] c, input logic [NT-1:0] p,
                        input bit upd);
    st = s; cl = c; sp = p; update_timers = upd;
    cycle();
    st = '0; cl = '0; sp = '0; update_timers = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  // Cycles until elapsed of instance k, channel ch is seen high (bounded).
  task automatic wait_el(input int k, input int ch, input int bound, output int n);
    n = 0;
    while (((k == 0) ? el1[ch] : el4[ch]) !== 1'b1 && n < bound) begin
      cycle();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, pulses, dbl, seen;
    bit prev;
    int a;

    // Reset
    model_reset();
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_el", 64'({el4, el1}), 64'd0);
    chk("rst_act", 64'({act4, act1}), 64'd0);
    reset_n = 1'b1;
    idle(2);

    // One-shot, limit 5
    wr(0, 32'd5); wr(1, 32'd0); wr(2, 32'd0);
    strobe(2'b01, 2'b01, 2'b00, 1);
    chk("os_act", 64'(act1[0]), 64'd1);
    wait_el(0, 0, 50, n);
    chk("os_latency", 64'(n), 64'd6);
    idle(5);
    chk("os_hold_el", 64'(el1[0]), 64'd1);
    chk("os_hold_act", 64'(act1[0]), 64'd0);
    strobe(2'b00, 2'b01, 2'b00, 1);
    chk("os_clear", 64'(el1[0]), 64'd0);

    // Auto-reload, ch1 limit 3
    wr(3, 32'd3); wr(4, 32'd0); wr(5, 32'd1);
    strobe(2'b10, 2'b10, 2'b00, 1);
    pulses = 0; dbl = 0; prev = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk("ar_active", 64'(act1[1]), 64'd1);
      if (el1[1] === 1'b1) begin
        pulses++;
        if (prev) dbl++;
      end
      prev = (el1[1] === 1'b1);
    end
    chk("ar_pulses", 64'(pulses), 64'd5);
    chk("ar_width", 64'(dbl), 64'd0);
    strobe(2'b00, 2'b00, 2'b10, 1);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (el1[1] === 1'b1) pulses++;
    end
    chk("ar_stopped", 64'(pulses), 64'd0);
    chk("ar_inactive", 64'(act1[1]), 64'd0);

    // 36-bit limit split across two words
    wr(0, 32'd2); wr(1, 32'hFFFF_FFF1);
    strobe(2'b01, 2'b01, 2'b00, 1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (el1[0] === 1'b1) seen++;
    end
    chk("big_limit_no_exp", 64'(seen), 64'd0);
    chk("big_limit_active", 64'(act1[0]), 64'd1);
    wr(1, 32'd0);
    cycle();
    chk("lowered_limit_exp", 64'(el1[0]), 64'd1);
    strobe(2'b01, 2'b01, 2'b00, 1);
    wait_el(0, 0, 50, n);
    chk("split_latency", 64'(n), 64'd3);

    // PRESCALE 4 instance, limit 2
    strobe(2'b01, 2'b01, 2'b00, 1);
    wait_el(1, 0, 60, n);
    chk("ps4_latency_window", 64'(n >= 9 && n <= 15), 64'd1);

    // start+stop in one cycle
    strobe(2'b10, 2'b10, 2'b10, 1);
    chk("start_stop_p1", 64'(act1[1]), 64'd0);
    chk("start_stop_p4", 64'(act4[1]), 64'd0);

    // Clear on the expiry edge (PRESCALE 1, limit 2)
    strobe(2'b01, 2'b01, 2'b00, 1);
    cycle(); cycle();
    strobe(2'b00, 2'b01, 2'b00, 1);
    chk("clr_at_exp_el", 64'(el1[0]), 64'd0);
    chk("clr_at_exp_act", 64'(act1[0]), 64'd0);
    idle(3);

    // Unqualified strobes do nothing
    strobe(2'b01, 2'b00, 2'b00, 1);
    wait_el(0, 0, 20, n);
    strobe(2'b11, 2'b11, 2'b00, 0);
    chk("noupd_el_kept", 64'(el1[0]), 64'd1);
    chk("noupd_no_start", 64'(act1), 64'd0);

    // Async reset mid-count (limit 100, cnt about 40)
    wr(0, 32'd100); wr(1, 32'd0);
    strobe(2'b01, 2'b01, 2'b00, 1);
    idle(40);
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_act", 64'({act4, act1}), 64'd0);
    chk("async_rst_el", 64'({el4, el1}), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(10);
    chk("post_rst_idle", 64'(act1[0]), 64'd0);
    strobe(2'b01, 2'b00, 2'b00, 1);
    wait_el(0, 0, 20, n);
    chk("post_rst_lim0", 64'(n), 64'd1);

    // Randomised traffic against the model
    repeat (400) begin
      wrenb = ($urandom_range(0, 3) == 0);
      a = $urandom_range(0, 7);
      wraddr = AW'(a);
      if (a % 3 == 0) config_data = $urandom_range(0, 12);
      else if (a % 3 == 1)
        config_data = ($urandom & 32'hFFFF_FFF0) | (($urandom_range(0, 9) == 0) ? 32'd1 : 32'd0);
      else config_data = $urandom;
      update_timers = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 3) == 0) ? NT'($urandom) : '0;
      cl = ($urandom_range(0, 4) == 0) ? NT'($urandom) : '0;
      sp = ($urandom_range(0, 6) == 0) ? NT'($urandom) : '0;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
